wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results take priority, long-latency results queue in an in-order FIFO.
// Optional macro WB_BYPASS_EN lets a long-path result skip an empty FIFO when the ALU is idle.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic [31:0] busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          alu_eff;
  logic          xfer;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;
  logic [31:0]   busy_next;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign lsu_ready = (count < DEPTH_C);

  always_comb begin
    alu_eff = alu_valid && (alu_rd != '0);
    xfer    = lsu_valid && lsu_ready && (lsu_rd != '0);
    pop     = !alu_eff && (count != '0);
`ifdef WB_BYPASS_EN
    bypass  = !alu_eff && (count == '0) && xfer;
`else
    bypass  = 1'b0;
`endif
    push    = xfer && !bypass;

    set_mask = '0;
    if (iss_valid) set_mask[iss_rd] = 1'b1;

    clr_mask = '0;
    if (pop)         clr_mask[fifo_rd[rd_ptr]] = 1'b1;
    else if (bypass) clr_mask[lsu_rd]          = 1'b1;

    // Clear before set so a same-edge re-issue keeps the bit pending.
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we     <= 1'b0;
      wa     <= '0;
      wd     <= '0;
      busy   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      we <= alu_eff || pop || bypass;
      if (alu_eff) begin
        wa <= alu_rd;
        wd <= alu_data;
      end else if (pop) begin
        wa <= fifo_rd[rd_ptr];
        wd <= fifo_data[rd_ptr];
      end else if (bypass) begin
        wa <= lsu_rd;
        wd <= lsu_data;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      busy <= busy_next;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus write-order scoreboard and multi-cycle sequences.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv;
    logic [4:0]  ird;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        erdy;
    logic [31:0] ebusy;
  } vec_t;

  wr_t  lsu_q[$];
  wr_t  alu_exp;
  bit   alu_pend;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird);
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ldat;
    iss_valid = iv;  iss_rd = ird;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  // One clock: record expected writes from the driven inputs, then compare what the DUT writes.
  task automatic step();
    wr_t e;
    chk("sb_lsu_ready", 32'(lsu_ready), 32'(lsu_q.size() < DEPTH));
    alu_pend = alu_valid && (alu_rd != 5'd0);
    alu_exp  = '{alu_rd, alu_data};
    if (lsu_valid && (lsu_rd != 5'd0) && (lsu_q.size() < DEPTH))
      lsu_q.push_back('{lsu_rd, lsu_data});
    @(posedge clk);
    #1;
    if (we) begin
      if (alu_pend) begin
        chk("sb_alu_wa", 32'(wa), 32'(alu_exp.rd));
        chk("sb_alu_wd", wd, alu_exp.data);
      end else if (lsu_q.size() > 0) begin
        e = lsu_q.pop_front();
        chk("sb_lsu_wa", 32'(wa), 32'(e.rd));
        chk("sb_lsu_wd", wd, e.data);
      end else begin
        chk("sb_spurious_we", 32'(we), 32'h0);
      end
    end else if (alu_pend) begin
      chk("sb_alu_missing_we", 32'(we), 32'h1);
    end
  endtask

  initial begin
    //          av ard adat        lv lrd ldat       iv ird   we wa wd          rdy busy
    tbl[0]  = '{1, 5,  32'h1234,   0, 0,  32'h0,     0, 0,    1, 5,  32'h1234, 1, 32'h0};
    tbl[1]  = '{1, 0,  32'hDEAD,   0, 0,  32'h0,     0, 0,    0, 5,  32'h1234, 1, 32'h0};
    tbl[2]  = '{0, 0,  32'h0,      0, 0,  32'h0,     1, 3,    0, 5,  32'h1234, 1, 32'h8};
    tbl[3]  = '{1, 1,  32'h11,     1, 7,  32'h700,   0, 0,    1, 1,  32'h11,   1, 32'h8};
    tbl[4]  = '{1, 2,  32'h22,     1, 8,  32'h800,   0, 0,    1, 2,  32'h22,   0, 32'h8};
    tbl[5]  = '{1, 3,  32'h33,     1, 9,  32'h900,   0, 0,    1, 3,  32'h33,   0, 32'h8};
    tbl[6]  = '{1, 4,  32'h44,     1, 9,  32'h900,   0, 0,    1, 4,  32'h44,   0, 32'h8};
    tbl[7]  = '{0, 0,  32'h0,      1, 9,  32'h900,   0, 0,    1, 7,  32'h700,  1, 32'h8};
    tbl[8]  = '{0, 0,  32'h0,      1, 9,  32'h900,   0, 0,    1, 8,  32'h800,  1, 32'h8};
    tbl[9]  = '{0, 0,  32'h0,      0, 0,  32'h0,     0, 0,    1, 9,  32'h900,  1, 32'h8};
    tbl[10] = '{1, 6,  32'h66,     1, 3,  32'h333,   0, 0,    1, 6,  32'h66,   1, 32'h8};
    tbl[11] = '{0, 0,  32'h0,      0, 0,  32'h0,     1, 3,    1, 3,  32'h333,  1, 32'h8};
    tbl[12] = '{1, 10, 32'hAA,     1, 3,  32'h334,   0, 0,    1, 10, 32'hAA,   1, 32'h8};
    tbl[13] = '{0, 0,  32'h0,      0, 0,  32'h0,     0, 0,    1, 3,  32'h334,  1, 32'h0};
    tbl[14] = '{0, 0,  32'h0,      0, 0,  32'h0,     1, 0,    0, 3,  32'h334,  1, 32'h0};
    tbl[15] = '{1, 1,  32'h55,     1, 0,  32'h999,   0, 0,    1, 1,  32'h55,   1, 32'h0};
    tbl[16] = '{0, 0,  32'h0,      0, 0,  32'h0,     0, 0,    0, 1,  32'h55,   1, 32'h0};

    rst_n = 1'b1;
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_we",    32'(we),        32'h0);
    chk("rst_wa",    32'(wa),        32'h0);
    chk("rst_wd",    wd,             32'h0);
    chk("rst_busy",  busy,           32'h0);
    chk("rst_ready", 32'(lsu_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat,
            tbl[i].iv, tbl[i].ird);
      step();
      chk($sformatf("v%0d_we", i),    32'(we),        32'(tbl[i].ewe));
      chk($sformatf("v%0d_wa", i),    32'(wa),        32'(tbl[i].ewa));
      chk($sformatf("v%0d_wd", i),    wd,             tbl[i].ewd);
      chk($sformatf("v%0d_ready", i), 32'(lsu_ready), 32'(tbl[i].erdy));
      chk($sformatf("v%0d_busy", i),  busy,           tbl[i].ebusy);
    end

    // Long-path latency with idle ALU and empty FIFO.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    step();
    chk("byp_busy_set", busy, 32'h10);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE, 1'b0, 5'd0);
    step();
`ifdef WB_BYPASS_EN
    chk("byp_we_n1",   32'(we), 32'h1);
    chk("byp_wa_n1",   32'(wa), 32'h4);
    chk("byp_wd_n1",   wd,      32'hCAFE);
    chk("byp_busy_n1", busy,    32'h0);
    idle();
    step();
    chk("byp_we_n2",   32'(we), 32'h0);
`else
    chk("byp_we_n1",   32'(we), 32'h0);
    chk("byp_busy_n1", busy,    32'h10);
    idle();
    step();
    chk("byp_we_n2",   32'(we), 32'h1);
    chk("byp_wa_n2",   32'(wa), 32'h4);
    chk("byp_wd_n2",   wd,      32'hCAFE);
    chk("byp_busy_n2", busy,    32'h0);
`endif

    // Back-to-back long-path transfers: push and pop every edge, pointers wrap repeatedly.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(11 + i), 32'hA000 + 32'(i), 1'b0, 5'd0);
      step();
      chk($sformatf("wrap%0d_ready", i), 32'(lsu_ready), 32'h1);
    end
    idle();
    step();
    chk("wrap_drained", 32'(lsu_q.size()), 32'h0);
    idle();
    step();
    chk("wrap_idle_we", 32'(we), 32'h0);

    // Reset mid-traffic with two entries queued and a pending busy bit.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h2000, 1'b1, 5'd20);
    step();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h2100, 1'b0, 5'd0);
    step();
    chk("mid_ready_full", 32'(lsu_ready), 32'h0);
    chk("mid_busy",       busy,           32'h0010_0000);
    drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    lsu_q.delete();
    alu_pend = 1'b0;
    chk("mrst_we",    32'(we),        32'h0);
    chk("mrst_wa",    32'(wa),        32'h0);
    chk("mrst_wd",    wd,             32'h0);
    chk("mrst_busy",  busy,           32'h0);
    chk("mrst_ready", 32'(lsu_ready), 32'h1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_ready_hold", 32'(lsu_ready), 32'h1);
    rst_n = 1'b1;
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    step();
    chk("post_rst_we", 32'(we), 32'h1);
    chk("post_rst_wa", 32'(wa), 32'h9);
    chk("post_rst_wd", wd,      32'h99);
    for (int i = 0; i < 3; i++) begin
      idle();
      step();
      chk($sformatf("post_rst_stale%0d", i), 32'(we), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
